// File: rtl/vga_pkg.sv
// Shared screen constants, direction/state encodings, colours and the
// saturating position helpers used by the sprite renderer.
package vga_pkg;

    localparam int unsigned H_RES = 640;
    localparam int unsigned V_RES = 480;
    localparam int unsigned X_W   = 10;
    localparam int unsigned Y_W   = 9;
    localparam int unsigned POS_W = 11;
    localparam int unsigned COL_W = 12;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } mv_state_e;

    localparam logic [COL_W-1:0] COL_WHITE = 12'hFFF;
    localparam logic [COL_W-1:0] COL_NAVY  = 12'h008;
    localparam logic [COL_W-1:0] COL_BLACK = 12'h000;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // Subtract, clamping at zero.
    function automatic logic [POS_W-1:0] sat_sub(input logic [POS_W-1:0] v,
                                                 input logic [POS_W-1:0] s);
        return (v < s) ? POS_W'(0) : v - s;
    endfunction

    // Add, clamping at lim; operands are small enough that the sum never wraps.
    function automatic logic [POS_W-1:0] sat_add(input logic [POS_W-1:0] v,
                                                 input logic [POS_W-1:0] s,
                                                 input logic [POS_W-1:0] lim);
        logic [POS_W-1:0] sum;
        sum = v + s;
        return (sum > lim) ? lim : sum;
    endfunction

endpackage

// File: rtl/sprite_pixel_pipe.sv
// Two-stage strobe-gated pipeline: sprite hit test, then colour select,
// with syncs carried alongside so they stay aligned with the colour.
module sprite_pixel_pipe
    import vga_pkg::*;
#(
    parameter int unsigned      SPR_W = 32,
    parameter int unsigned      SPR_H = 32,
    parameter logic [COL_W-1:0] FG    = COL_WHITE,
    parameter logic [COL_W-1:0] BG    = COL_NAVY
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_pix_stb,
    input  logic           i_hs,
    input  logic           i_vs,
    input  logic           i_active,
    input  logic [X_W-1:0] i_x,
    input  logic [Y_W-1:0] i_y,
    input  logic [X_W-1:0] i_spr_x,
    input  logic [Y_W-1:0] i_spr_y,
    output logic           o_hs,
    output logic           o_vs,
    output rgb_t           o_rgb
);

    localparam logic [POS_W-1:0] W11 = POS_W'(SPR_W);
    localparam logic [POS_W-1:0] H11 = POS_W'(SPR_H);

    logic [POS_W-1:0] px_c, py_c, sx_c, sy_c;
    logic             hit_c;
    logic             s1_hit, s1_active, s1_hs, s1_vs;

    assign px_c  = POS_W'(i_x);
    assign py_c  = POS_W'(i_y);
    assign sx_c  = POS_W'(i_spr_x);
    assign sy_c  = POS_W'(i_spr_y);
    assign hit_c = i_active && (px_c >= sx_c) && (px_c < sx_c + W11)
                            && (py_c >= sy_c) && (py_c < sy_c + H11);

    // Stage 1: hit test and sync/active capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_hit    <= 1'b0;
            s1_active <= 1'b0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
        end else if (i_pix_stb) begin
            s1_hit    <= hit_c;
            s1_active <= i_active;
            s1_hs     <= i_hs;
            s1_vs     <= i_vs;
        end
    end

    // Stage 2: colour select; blanking forces black.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rgb <= rgb_t'(COL_BLACK);
            o_hs  <= 1'b1;
            o_vs  <= 1'b1;
        end else if (i_pix_stb) begin
            o_rgb <= s1_active ? (s1_hit ? rgb_t'(FG) : rgb_t'(BG)) : rgb_t'(COL_BLACK);
            o_hs  <= s1_hs;
            o_vs  <= s1_vs;
        end
    end

endmodule

// File: rtl/sprite_renderer.sv
// Single-sprite renderer behind the VGA timing generator; moves commit only
// at the frame tick. Optional SPRITE_BOUNCE_EN adds autonomous diagonal bounce.
module sprite_renderer
    import vga_pkg::*;
#(
    parameter int unsigned      SPR_W = 32,
    parameter int unsigned      SPR_H = 32,
    parameter int unsigned      STEP  = 4,
    parameter int unsigned      X0    = 304,
    parameter int unsigned      Y0    = 224,
    parameter logic [COL_W-1:0] FG    = COL_WHITE,
    parameter logic [COL_W-1:0] BG    = COL_NAVY
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_pix_stb,
    input  logic           i_hs,
    input  logic           i_vs,
    input  logic           i_active,
    input  logic           i_animate,
    input  logic [X_W-1:0] i_x,
    input  logic [Y_W-1:0] i_y,
    input  logic           i_mv_valid,
    input  logic [1:0]     i_mv_dir,
    output logic           o_mv_ready,
    output logic           o_hs,
    output logic           o_vs,
    output logic [3:0]     o_r,
    output logic [3:0]     o_g,
    output logic [3:0]     o_b,
    output logic [X_W-1:0] o_spr_x,
    output logic [Y_W-1:0] o_spr_y
);

    localparam logic [POS_W-1:0] STEP11 = POS_W'(STEP);
    localparam logic [POS_W-1:0] X_MAX  = POS_W'(H_RES - SPR_W);
    localparam logic [POS_W-1:0] Y_MAX  = POS_W'(V_RES - SPR_H);

    mv_state_e        state_q, state_d;
    logic [1:0]       dir_q, dir_d;
    logic [X_W-1:0]   spr_x_q, spr_x_d;
    logic [Y_W-1:0]   spr_y_q, spr_y_d;
    logic [POS_W-1:0] x11_c, y11_c;
    logic             frame_tick_c;
    rgb_t             pix_rgb;

    assign frame_tick_c = i_animate & i_pix_stb;
    assign x11_c        = POS_W'(spr_x_q);
    assign y11_c        = POS_W'(spr_y_q);

`ifdef SPRITE_BOUNCE_EN
    logic             bx_q, bx_d, by_q, by_d;
    logic [POS_W-1:0] bounce_x_c, bounce_y_c;

    assign bounce_x_c = bx_q ? sat_add(x11_c, STEP11, X_MAX) : sat_sub(x11_c, STEP11);
    assign bounce_y_c = by_q ? sat_add(y11_c, STEP11, Y_MAX) : sat_sub(y11_c, STEP11);
`endif

    // Command FSM and position next-state.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        spr_x_d = spr_x_q;
        spr_y_d = spr_y_q;
`ifdef SPRITE_BOUNCE_EN
        bx_d    = bx_q;
        by_d    = by_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (i_mv_valid) begin
                    dir_d   = i_mv_dir;
                    state_d = ST_PENDING;
                end
`ifdef SPRITE_BOUNCE_EN
                if (frame_tick_c) begin
                    spr_x_d = X_W'(bounce_x_c);
                    spr_y_d = Y_W'(bounce_y_c);
                    bx_d    = bx_q ? (bounce_x_c != X_MAX) : (bounce_x_c == POS_W'(0));
                    by_d    = by_q ? (bounce_y_c != Y_MAX) : (bounce_y_c == POS_W'(0));
                end
`endif
            end
            ST_PENDING: begin
                if (frame_tick_c) state_d = ST_APPLY;
            end
            ST_APPLY: begin
                state_d = ST_IDLE;
                case (dir_q)
                    DIR_UP:   spr_y_d = Y_W'(sat_sub(y11_c, STEP11));
                    DIR_DOWN: spr_y_d = Y_W'(sat_add(y11_c, STEP11, Y_MAX));
                    DIR_LEFT: spr_x_d = X_W'(sat_sub(x11_c, STEP11));
                    default:  spr_x_d = X_W'(sat_add(x11_c, STEP11, X_MAX));
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_UP;
            spr_x_q <= X_W'(X0);
            spr_y_q <= Y_W'(Y0);
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            spr_x_q <= spr_x_d;
            spr_y_q <= spr_y_d;
        end
    end

`ifdef SPRITE_BOUNCE_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bx_q <= 1'b1;
            by_q <= 1'b1;
        end else begin
            bx_q <= bx_d;
            by_q <= by_d;
        end
    end
`endif

    assign o_mv_ready = (state_q == ST_IDLE);
    assign o_spr_x    = spr_x_q;
    assign o_spr_y    = spr_y_q;

    sprite_pixel_pipe #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .FG    (FG),
        .BG    (BG)
    ) u_pipe (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_pix_stb (i_pix_stb),
        .i_hs      (i_hs),
        .i_vs      (i_vs),
        .i_active  (i_active),
        .i_x       (i_x),
        .i_y       (i_y),
        .i_spr_x   (spr_x_q),
        .i_spr_y   (spr_y_q),
        .o_hs      (o_hs),
        .o_vs      (o_vs),
        .o_rgb     (pix_rgb)
    );

    assign o_r = pix_rgb.r;
    assign o_g = pix_rgb.g;
    assign o_b = pix_rgb.b;

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench for sprite_renderer: pixel expectations queued by the
// driver, popped by a strobe monitor; position checked against a plain model.
module tb_sprite_renderer;
    import vga_pkg::*;

    localparam int STEP = 4;
    localparam int SW   = 32;
    localparam int SH   = 32;
    localparam int XMAX = 640 - SW;
    localparam int YMAX = 480 - SH;

    logic       clk;
    logic       i_rst, i_pix_stb, i_hs, i_vs, i_active, i_animate;
    logic [9:0] i_x;
    logic [8:0] i_y;
    logic       i_mv_valid;
    logic [1:0] i_mv_dir;
    logic       o_mv_ready, o_hs, o_vs;
    logic [3:0] o_r, o_g, o_b;
    logic [9:0] o_spr_x;
    logic [8:0] o_spr_y;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int         mx, my;
    bit         bx, by;
    bit         pend;
    logic [1:0] pend_d;
    logic [13:0] sb_q[$];

    sprite_renderer dut (
        .i_clk(clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb), .i_hs(i_hs), .i_vs(i_vs),
        .i_active(i_active), .i_animate(i_animate), .i_x(i_x), .i_y(i_y),
        .i_mv_valid(i_mv_valid), .i_mv_dir(i_mv_dir), .o_mv_ready(o_mv_ready),
        .o_hs(o_hs), .o_vs(o_vs), .o_r(o_r), .o_g(o_g), .o_b(o_b),
        .o_spr_x(o_spr_x), .o_spr_y(o_spr_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic logic [13:0] exp_pix(input bit act, input bit hs, input bit vs,
                                            input int x, input int y);
        bit in_spr;
        logic [11:0] rgb;
        in_spr = (x >= mx) && (x < mx + SW) && (y >= my) && (y < my + SH);
        rgb = !act ? 12'h000 : (in_spr ? 12'hFFF : 12'h008);
        return {hs, vs, rgb};
    endfunction

    task automatic model_reset();
        mx = 304; my = 224; bx = 1'b1; by = 1'b1; pend = 1'b0;
        sb_q.delete();
    endtask

    task automatic model_apply(input logic [1:0] d);
        case (d)
            DIR_UP:   my = clampi(my - STEP, 0, YMAX);
            DIR_DOWN: my = clampi(my + STEP, 0, YMAX);
            DIR_LEFT: mx = clampi(mx - STEP, 0, XMAX);
            default:  mx = clampi(mx + STEP, 0, XMAX);
        endcase
    endtask

    task automatic model_tick();
        if (pend) begin
            model_apply(pend_d);
            pend = 1'b0;
        end else begin
`ifdef SPRITE_BOUNCE_EN
            mx = clampi(bx ? mx + STEP : mx - STEP, 0, XMAX);
            my = clampi(by ? my + STEP : my - STEP, 0, YMAX);
            if (bx ? (mx == XMAX) : (mx == 0)) bx = ~bx;
            if (by ? (my == YMAX) : (my == 0)) by = ~by;
`endif
        end
    endtask

    // One pixel period: a non-strobe cycle, then the strobe cycle.
    task automatic pixel_period(input bit act, input bit hs, input bit vs,
                                input int x, input int y, input bit anim);
        @(negedge clk);
        i_pix_stb = 1'b0; i_active = act; i_hs = hs; i_vs = vs;
        i_x = 10'(x); i_y = 9'(y); i_animate = anim;
        @(negedge clk);
        i_pix_stb = 1'b1;
        sb_q.push_back(exp_pix(act, hs, vs, x, y));
        if (anim) model_tick();
    endtask

    task automatic tick_period();
        pixel_period(1'b0, 1'b1, 1'b1, 700, 500, 1'b1);
    endtask

    task automatic rand_period();
        int x, y;
        if ($urandom_range(0, 1) == 0) begin
            x = clampi(mx - 8 + int'($urandom_range(0, 47)), 0, 799);
            y = clampi(my - 8 + int'($urandom_range(0, 47)), 0, 511);
        end else begin
            x = int'($urandom_range(0, 799));
            y = int'($urandom_range(0, 511));
        end
        pixel_period((x < 640) && (y < 480), !((x >= 656) && (x < 752)),
                     !((y == 490) || (y == 491)), x, y, 1'b0);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        i_pix_stb = 1'b0; i_animate = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        i_pix_stb = 1'b0; i_animate = 1'b0; i_mv_valid = 1'b1; i_mv_dir = d;
        while (!o_mv_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("cmd_ready_timeout", 0, 1);
        @(negedge clk);
        i_mv_valid = 1'b0;
        pend = 1'b1; pend_d = d;
    endtask

    task automatic do_move(input logic [1:0] d);
        int ox, oy;
        ox = mx; oy = my;
        send_cmd(d);
        check("ready_pending", int'(o_mv_ready), 0);
        rand_period();
        check("x_held", int'(o_spr_x), ox);
        check("y_held", int'(o_spr_y), oy);
        tick_period();
        idle_cycle();
        check("ready_apply", int'(o_mv_ready), 0);
        idle_cycle();
        check("x_move", int'(o_spr_x), mx);
        check("y_move", int'(o_spr_y), my);
        check("ready_idle", int'(o_mv_ready), 1);
    endtask

    task automatic reset_checks();
        check("rst_ready", int'(o_mv_ready), 1);
        check("rst_x", int'(o_spr_x), 304);
        check("rst_y", int'(o_spr_y), 224);
        check("rst_rgb", int'({o_r, o_g, o_b}), 0);
        check("rst_hs", int'(o_hs), 1);
        check("rst_vs", int'(o_vs), 1);
    endtask

    // Monitor: each strobe presents the pixel captured one strobe earlier.
    always @(posedge clk) begin
        if (i_pix_stb && !i_rst) begin
            #1;
            if (sb_q.size() >= 2) begin
                logic [13:0] e;
                e = sb_q.pop_front();
                check("pixel", int'({o_hs, o_vs, o_r, o_g, o_b}), int'(e));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_pix_stb = 1'b0; i_hs = 1'b1; i_vs = 1'b1; i_active = 1'b0;
        i_animate = 1'b0; i_x = '0; i_y = '0; i_mv_valid = 1'b0; i_mv_dir = DIR_UP;
        model_reset();
        repeat (2) @(negedge clk);
        reset_checks();
        i_rst = 1'b0;

        // Directed pixels: centre, both edges, blanking, sync passthrough.
        pixel_period(1'b1, 1'b1, 1'b1, 320, 240, 1'b0);
        pixel_period(1'b1, 1'b1, 1'b1, 303, 240, 1'b0);
        pixel_period(1'b1, 1'b1, 1'b1, 336, 240, 1'b0);
        pixel_period(1'b1, 1'b1, 1'b1, 304, 255, 1'b0);
        pixel_period(1'b1, 1'b1, 1'b1, 335, 256, 1'b0);
        pixel_period(1'b0, 1'b1, 1'b1, 700, 240, 1'b0);
        pixel_period(1'b0, 1'b0, 1'b1, 700, 240, 1'b0);
        pixel_period(1'b0, 1'b1, 1'b0, 100, 490, 1'b0);
        pixel_period(1'b0, 1'b1, 1'b1, 0, 500, 1'b0);

        // Random frames with ticks (no commands).
        for (int f = 0; f < 6; f++) begin
            for (int p = 0; p < 30; p++) rand_period();
            tick_period();
        end

        // Single right move mid-frame.
        do_move(DIR_RIGHT);

        // Saturating left, right, up, down sweeps.
        for (int i = 0; i < 80; i++) do_move(DIR_LEFT);
        check("x_left_floor", int'(o_spr_x), 0);
        for (int i = 0; i < 160; i++) do_move(DIR_RIGHT);
        check("x_right_clamp", int'(o_spr_x), 608);
        for (int i = 0; i < 60; i++) do_move(DIR_UP);
        for (int i = 0; i < 120; i++) do_move(DIR_DOWN);

        // Random command mix.
        for (int i = 0; i < 30; i++) begin
            do_move(2'($urandom_range(0, 3)));
            repeat (3) rand_period();
        end

        // Handshake coincident with a frame tick commits one frame later.
        @(negedge clk);
        i_pix_stb = 1'b0; i_animate = 1'b1; i_active = 1'b0; i_hs = 1'b1; i_vs = 1'b1;
        i_x = 10'(700); i_y = 9'(500);
        @(negedge clk);
        check("ready_coinc", int'(o_mv_ready), 1);
        i_pix_stb = 1'b1; i_mv_valid = 1'b1; i_mv_dir = DIR_UP;
        sb_q.push_back(exp_pix(1'b0, 1'b1, 1'b1, 700, 500));
        model_tick();
        pend = 1'b1; pend_d = DIR_UP;
        @(negedge clk);
        i_mv_valid = 1'b0; i_pix_stb = 1'b0; i_animate = 1'b0;
        check("coinc_pending", int'(o_mv_ready), 0);
        idle_cycle();
        check("coinc_y_held", int'(o_spr_y), my);
        for (int p = 0; p < 10; p++) rand_period();
        tick_period();
        idle_cycle();
        idle_cycle();
        check("coinc_y_move", int'(o_spr_y), my);
        check("coinc_x", int'(o_spr_x), mx);

        // Reset while PENDING drops the command and flushes the pipeline.
        pixel_period(1'b1, 1'b1, 1'b1, mx + 1, my + 1, 1'b0);
        pixel_period(1'b0, 1'b1, 1'b1, 700, 500, 1'b0);
        send_cmd(DIR_DOWN);
        @(negedge clk);
        i_rst = 1'b1;
        model_reset();
        @(negedge clk);
        reset_checks();
        i_rst = 1'b0;
        tick_period();
        idle_cycle();
        idle_cycle();
        check("drop_x", int'(o_spr_x), mx);
        check("drop_y", int'(o_spr_y), my);
        for (int p = 0; p < 10; p++) rand_period();

`ifdef SPRITE_BOUNCE_EN
        @(negedge clk);
        i_rst = 1'b1;
        model_reset();
        @(negedge clk);
        i_rst = 1'b0;
        for (int f = 0; f < 10; f++) tick_period();
        idle_cycle();
        idle_cycle();
        check("bounce_x", int'(o_spr_x), 344);
        check("bounce_y", int'(o_spr_y), 264);
`endif

        repeat (4) idle_cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sprite_renderer.md
# sprite_renderer

Pixel-colour stage directly downstream of the 640x480 VGA timing generator. It consumes the generator's pixel coordinates, active flag, syncs and end-of-active-frame tick, and draws one rectangular sprite over a solid background. Output is registered 4-bit-per-channel RGB, with syncs delayed to stay aligned with it. The sprite position moves through a valid/ready command interface. Moves are committed only at the end-of-active-frame tick, so the picture never tears.

## Interface
Parameters:
- SPR_W, 32: sprite width in pixels.
- SPR_H, 32: sprite height in pixels.
- STEP, 4: pixels moved per accepted command (and per bounce frame).
- X0, 304: reset x position.
- Y0, 224: reset y position.
- FG, 12'hFFF: sprite colour as {r,g,b}.
- BG, 12'h008: background colour as {r,g,b}.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_pix_stb  in  1  pixel strobe; all pixel-pipeline stages advance only when it is high.
- i_hs, i_vs  in  1 each  active-low syncs from the timing generator.
- i_active  in  1  high during active pixels.
- i_animate  in  1  end-of-active-frame tick from the timing generator.
- i_x  in  10  current pixel x.
- i_y  in  9  current pixel y.
- i_mv_valid  in  1  move request.
- i_mv_dir  in  2  move direction: 0 up, 1 down, 2 left, 3 right.
- o_mv_ready  out  1  high while a command can be accepted.
- o_hs, o_vs  out  1 each  delayed syncs.
- o_r, o_g, o_b  out  4 each  pixel colour.
- o_spr_x  out  10  committed sprite x.
- o_spr_y  out  9  committed sprite y.

## Operation
Command FSM, advancing every i_clk:
- States are IDLE, PENDING and APPLY.
- o_mv_ready = (state == IDLE).
- IDLE: on i_mv_valid & o_mv_ready, latch i_mv_dir and go to PENDING.
- PENDING: hold. On i_animate & i_pix_stb (the frame tick), go to APPLY. New requests are not accepted.
- APPLY: update the position for one cycle, then return to IDLE.

Position arithmetic is done in 11 bits, then truncated:
- up: y = (y < STEP) ? 0 : y - STEP.
- down: y = min(y + STEP, 480 - SPR_H).
- left: x = (x < STEP) ? 0 : x - STEP.
- right: x = min(x + STEP, 640 - SPR_W).

Pixel pipeline, two stages, both gated by i_pix_stb:
- Stage 1 registers hit = i_active & (spr_x <= i_x < spr_x + SPR_W) & (spr_y <= i_y < spr_y + SPR_H). It also registers i_active, i_hs and i_vs.
- Stage 2 registers colour = active ? (hit ? FG : BG) : 12'h000, plus the delayed syncs.

## Timing
- Latency: two pixel strobes from inputs to o_r/o_g/o_b, o_hs and o_vs. Syncs and colour are always mutually aligned.
- The frame tick is i_animate & i_pix_stb, which fires once per frame even though i_animate spans a whole strobe period.
- A move that is handshaken in the same cycle as a frame tick is committed at the next frame's tick, not the current one.
- o_spr_x/o_spr_y change only in APPLY. They therefore never change while the visible area is being scanned.
- A request arriving while o_mv_ready is low is not accepted. The requester holds i_mv_valid until it sees ready.

Reset (sampled on a rising i_clk edge), with values visible after that edge:
- FSM goes to IDLE, so o_mv_ready = 1.
- o_spr_x = X0, o_spr_y = Y0.
- Pipeline is flushed: o_r/o_g/o_b = 0, o_hs = o_vs = 1.
- Reset mid-PENDING discards the latched command.

## Configuration
- SPRITE_BOUNCE_EN defined:
  - At each frame tick with no command PENDING, the sprite moves diagonally by STEP on both axes.
  - Two direction flags, reset to +x/+y, invert when the clamped result reaches an edge.
  - A PENDING command takes priority for that frame; bounce flags are unchanged.
- SPRITE_BOUNCE_EN undefined: the sprite moves only on commands, and the direction flags are not built.

## Structure
- Shared package vga_pkg holds:
  - screen constants H_RES = 640 and V_RES = 480;
  - direction encodings DIR_UP/DOWN/LEFT/RIGHT;
  - the FSM state encodings;
  - the 12-bit colour constants.
- One sub-module, sprite_pixel_pipe, implements the two-stage hit/colour/sync pipeline. The top level owns the FSM and position registers.

## Test plan
- Reset → o_spr_x = 304, o_spr_y = 224, o_mv_ready = 1, RGB = 0/0/0, o_hs = o_vs = 1.
- Active pixel (320,240) → RGB F/F/F two strobes later. Pixels (303,240) and (336,240) → 0/0/8. Any blanking pixel → 0/0/0.
- Right command accepted mid-frame → o_mv_ready stays 0 and o_spr_x stays 304 until the frame tick. o_spr_x = 308 after APPLY, and o_mv_ready = 1 the following cycle.
- 80 left commands from x = 304 → x reaches 0 after 76 and stays 0. Right commands from x = 606 → x clamps to 608.
- i_hs low at strobe n → o_hs low at strobe n+2. Handshake coincident with a frame tick → move commits one frame later.
- Reset asserted in PENDING → command dropped, position 304/224. With SPRITE_BOUNCE_EN, 10 idle frames → 344/264.
